rect_plotter: RTL

- Parametrised successor to the 4x4 box drawer for the 160x120 VGA adapter path.
- Latches a start coordinate, a width/height and a colour, then emits one pixel per clock in raster order to the VGA adapter (oX/oY/oColour/oPlot).
- Also provides a full-screen clear mode.
- Pixels that fall off the right or bottom screen edge are clipped; cycle count is unchanged.

---
 rtl/rect_plotter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/rect_plotter.sv
// rect_plotter: latches a rectangle (x, y, w, h, colour) and emits one pixel
// per clock in raster order to the 160x120 VGA adapter; also offers a
// full-screen clear. Off-screen pixels are clipped without changing timing.
// Optional build macro: RECT_OUTLINE_EN (adds iOutline, border-only drawing).
module rect_plotter #(
  parameter int         X_SCREEN_PIXELS = 160,
  parameter int         Y_SCREEN_PIXELS = 120,
  parameter int         SIZE_BITS       = 4,
  parameter logic [2:0] CLEAR_COLOUR    = 3'b000
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic                 iStart,
  input  logic                 iClear,
  input  logic [7:0]           iX,
  input  logic [6:0]           iY,
  input  logic [SIZE_BITS-1:0] iW,
  input  logic [SIZE_BITS-1:0] iH,
  input  logic [2:0]           iColour,
`ifdef RECT_OUTLINE_EN
  input  logic                 iOutline,
`endif
  output logic [7:0]           oX,
  output logic [6:0]           oY,
  output logic [2:0]           oColour,
  output logic                 oPlot,
  output logic                 oBusy,
  output logic                 oDone
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAW  = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  localparam logic [7:0] X_LAST = 8'(X_SCREEN_PIXELS - 1);
  localparam logic [6:0] Y_LAST = 7'(Y_SCREEN_PIXELS - 1);

  logic [1:0]           r_state;
  logic [7:0]           r_x;
  logic [6:0]           r_y;
  logic [SIZE_BITS-1:0] r_w;
  logic [SIZE_BITS-1:0] r_h;
  logic [2:0]           r_col;
  logic [7:0]           r_dx;
  logic [6:0]           r_dy;
  logic                 r_fin;
  logic [7:0]           r_oX;
  logic [6:0]           r_oY;
  logic [2:0]           r_oColour;
  logic                 r_oPlot;
  logic                 r_oBusy;
  logic                 r_oDone;
`ifdef RECT_OUTLINE_EN
  logic                 r_outline;
  logic                 w_border;
`endif

  logic [8:0] w_sx;
  logic [7:0] w_sy;
  logic [7:0] w_x_last;
  logic [6:0] w_y_last;
  logic       w_at_x_end;
  logic       w_at_y_end;
  logic       w_in_screen;
  logic       w_plot;

  // Pixel address, sweep limits and plot enable for the current offset.
  // Clear mode reuses the draw datapath with origin (0,0) and screen-size limits.
  always_comb begin
    w_sx        = {1'b0, r_x} + {1'b0, r_dx};
    w_sy        = {1'b0, r_y} + {1'b0, r_dy};
    w_x_last    = (r_state == S_CLEAR) ? X_LAST : 8'(r_w) - 8'd1;
    w_y_last    = (r_state == S_CLEAR) ? Y_LAST : 7'(r_h) - 7'd1;
    w_at_x_end  = (r_dx == w_x_last);
    w_at_y_end  = (r_dy == w_y_last);
    w_in_screen = (w_sx < 9'(X_SCREEN_PIXELS)) && (w_sy < 8'(Y_SCREEN_PIXELS));
`ifdef RECT_OUTLINE_EN
    w_border    = (r_dx == 8'd0) || w_at_x_end || (r_dy == 7'd0) || w_at_y_end;
    w_plot      = (r_state == S_CLEAR) ? 1'b1
                : (w_in_screen && (!r_outline || w_border));
`else
    w_plot      = (r_state == S_CLEAR) ? 1'b1 : w_in_screen;
`endif
  end

  // Request acceptance, raster sweep and completion handshake.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      r_state   <= S_IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_col     <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_fin     <= 1'b0;
      r_oX      <= '0;
      r_oY      <= '0;
      r_oColour <= '0;
      r_oPlot   <= 1'b0;
      r_oBusy   <= 1'b0;
      r_oDone   <= 1'b0;
`ifdef RECT_OUTLINE_EN
      r_outline <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_oPlot <= 1'b0;
          r_dx    <= '0;
          r_dy    <= '0;
          r_fin   <= 1'b0;
          if (iClear) begin
            r_state <= S_CLEAR;
            r_x     <= '0;
            r_y     <= '0;
            r_oBusy <= 1'b1;
            r_oDone <= 1'b0;
`ifdef RECT_OUTLINE_EN
            r_outline <= 1'b0;
`endif
          end else if (iStart) begin
            r_x   <= iX;
            r_y   <= iY;
            r_w   <= iW;
            r_h   <= iH;
            r_col <= iColour;
`ifdef RECT_OUTLINE_EN
            r_outline <= iOutline;
`endif
            // An empty rectangle completes on the accepting edge itself.
            if ((iW == '0) || (iH == '0)) begin
              r_oDone <= 1'b1;
            end else begin
              r_state <= S_DRAW;
              r_oBusy <= 1'b1;
              r_oDone <= 1'b0;
            end
          end
        end
        S_DRAW, S_CLEAR: begin
          if (r_fin) begin
            r_state <= S_IDLE;
            r_oPlot <= 1'b0;
            r_oBusy <= 1'b0;
            r_oDone <= 1'b1;
          end else begin
            r_oX      <= w_sx[7:0];
            r_oY      <= w_sy[6:0];
            r_oColour <= (r_state == S_CLEAR) ? CLEAR_COLOUR : r_col;
            r_oPlot   <= w_plot;
            if (w_at_x_end) begin
              r_dx <= '0;
              if (w_at_y_end) r_fin <= 1'b1;
              else            r_dy  <= r_dy + 7'd1;
            end else begin
              r_dx <= r_dx + 8'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oX      = r_oX;
  assign oY      = r_oY;
  assign oColour = r_oColour;
  assign oPlot   = r_oPlot;
  assign oBusy   = r_oBusy;
  assign oDone   = r_oDone;

endmodule
